// File: rtl/adc_pkg.sv
// Shared ADC definitions: rectification mode encodings and mid-scale helper.
package adc_pkg;

   localparam logic [1:0] MODE_BYPASS = 2'b00;
   localparam logic [1:0] MODE_HALF   = 2'b01;
   localparam logic [1:0] MODE_FULL   = 2'b10;

   function automatic int mid_scale(input int width);
      return 1 << (width - 1);
   endfunction

endpackage

// File: rtl/adc_rectify.sv
// Offset-binary sample to magnitude-from-mid-scale, one registered stage.
// Latency 1 cycle din_valid -> mag_valid; no backpressure, accepts every sample.
module adc_rectify
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   input  logic [1:0]            mode,
   output logic [DATA_WIDTH-1:0] mag,
   output logic                  mag_valid
);

   localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(mid_scale(DATA_WIDTH));

   logic                  above_mid;
   logic [DATA_WIDTH-1:0] mag_nxt;

   // Mode 11 falls into the default arm and rectifies like full mode.
   always_comb begin
      above_mid = (din >= MID);
      mag_nxt   = '0;
      case (mode)
         MODE_BYPASS: mag_nxt = din;
         MODE_HALF:   mag_nxt = above_mid ? (din - MID) : '0;
         default:     mag_nxt = above_mid ? (din - MID) : (MID - din);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mag       <= '0;
         mag_valid <= 1'b0;
      end else begin
         mag_valid <= din_valid;
         if (din_valid) begin
            mag <= mag_nxt;
         end
      end
   end

endmodule

// File: rtl/adc_envelope.sv
// Rectified magnitude plus per-window peak and truncated mean over 2^WIN_LOG2 samples.
// Latency 2 cycles last din_valid -> win_valid; no backpressure, one sample per cycle.
module adc_envelope
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int WIN_LOG2   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   input  logic [1:0]            mode,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] mag,
   output logic                  mag_valid,
   output logic [DATA_WIDTH-1:0] peak,
   output logic [DATA_WIDTH-1:0] avg,
   output logic                  win_valid
);

   localparam int SUM_W = DATA_WIDTH + WIN_LOG2;

   logic [WIN_LOG2-1:0]   cnt;
   logic [SUM_W-1:0]      sum;
   logic [DATA_WIDTH-1:0] max_val;
   logic [SUM_W-1:0]      sum_nxt;
   logic [DATA_WIDTH-1:0] max_nxt;
   logic                  first;

   adc_rectify #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rectify (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .mode      (mode),
      .mag       (mag),
      .mag_valid (mag_valid)
   );

   // A zero count marks the first sample of a window: load instead of accumulate.
   always_comb begin
      first   = (cnt == '0);
      sum_nxt = first ? {{WIN_LOG2{1'b0}}, mag} : (sum + {{WIN_LOG2{1'b0}}, mag});
      max_nxt = (first || (mag > max_val)) ? mag : max_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         sum       <= '0;
         max_val   <= '0;
         peak      <= '0;
         avg       <= '0;
         win_valid <= 1'b0;
      end else begin
         win_valid <= 1'b0;
         if (clear) begin
            cnt <= '0;
         end else if (mag_valid) begin
            sum     <= sum_nxt;
            max_val <= max_nxt;
            cnt     <= cnt + 1'b1;
            if (cnt == '1) begin
               peak      <= max_nxt;
               avg       <= sum_nxt[SUM_W-1:WIN_LOG2];
               win_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_envelope.sv
// Randomized and directed bench for adc_envelope against a queue-based window model.
module tb_adc_envelope;

   localparam int DW  = 12;
   localparam int WL  = 2;
   localparam int WIN = 1 << WL;
   localparam int MID = 1 << (DW - 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          clear = 1'b0;
   logic [DW-1:0] mag;
   logic          mag_valid;
   logic [DW-1:0] peak;
   logic [DW-1:0] avg;
   logic          win_valid;

   int checks   = 0;
   int failures = 0;
   int wins     = 0;

   // reference model state
   int e_mag    = 0;
   bit e_mvld   = 0;
   int e_peak   = 0;
   int e_avg    = 0;
   bit e_win    = 0;
   int window[$];

   adc_envelope #(
      .DATA_WIDTH (DW),
      .WIN_LOG2   (WL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .mode      (mode),
      .clear     (clear),
      .mag       (mag),
      .mag_valid (mag_valid),
      .peak      (peak),
      .avg       (avg),
      .win_valid (win_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_mag(input int d, input int m);
      if (m == 0) return d;
      if (d >= MID) return d - MID;
      if (m == 1) return 0;
      return MID - d;
   endfunction

   // Advance the model by one clock edge using the inputs sampled at that edge.
   task automatic model(input int d, input bit v, input int m, input bit c, input bit r);
      int mx;
      int sm;
      if (r) begin
         e_mag = 0; e_mvld = 0; e_peak = 0; e_avg = 0; e_win = 0;
         window.delete();
         return;
      end
      e_win = 0;
      if (c) begin
         window.delete();
      end else if (e_mvld) begin
         window.push_back(e_mag);
         if (window.size() == WIN) begin
            mx = 0; sm = 0;
            foreach (window[i]) begin
               sm += window[i];
               if (window[i] > mx) mx = window[i];
            end
            e_peak = mx;
            e_avg  = sm / WIN;
            e_win  = 1;
            window.delete();
         end
      end
      e_mvld = v;
      if (v) e_mag = ref_mag(d, m);
   endtask

   task automatic step(input int d, input bit v, input int m, input bit c, input bit r);
      din = DW'(d); din_valid = v; mode = 2'(m); clear = c; rst = r;
      @(posedge clk);
      model(d, v, m, c, r);
      @(negedge clk);
      chk("mag_valid", mag_valid, e_mvld);
      chk("mag", mag, e_mag);
      chk("win_valid", win_valid, e_win);
      chk("peak", peak, e_peak);
      chk("avg", avg, e_avg);
      if (win_valid) wins++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int half_d[4];
      int full_d[4];
      int w0;
      half_d = '{2048, 3000, 1000, 4095};
      full_d = '{2058, 2028, 2078, 2008};

      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("rst_mag", mag, 0);
      chk("rst_peak", peak, 0);
      idle(1);

      // half and full/bypass magnitude patterns
      foreach (half_d[i]) step(half_d[i], 1, 1, 0, 0);
      step(0, 1, 2, 0, 0);
      step(2047, 1, 2, 0, 0);
      step(2048, 1, 2, 0, 0);
      step(1234, 1, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 1, 0);

      // full-mode window, fifth sample immediately starts the next window
      w0 = wins;
      foreach (full_d[i]) step(full_d[i], 1, 2, 0, 0);
      step(2053, 1, 2, 0, 0);
      idle(2);
      chk("full_wins", wins - w0, 1);
      chk("full_peak", peak, 40);
      chk("full_avg", avg, 25);
      step(0, 0, 0, 1, 0);

      // same data with random gaps
      w0 = wins;
      foreach (full_d[i]) begin
         step(full_d[i], 1, 2, 0, 0);
         idle($urandom_range(0, 5));
      end
      idle(2);
      chk("gap_wins", wins - w0, 1);
      chk("gap_peak", peak, 40);
      chk("gap_avg", avg, 25);

      // partial window aborted by clear
      w0 = wins;
      for (int i = 0; i < 3; i++) step(2055, 1, 2, 0, 0);
      idle(1);
      step(0, 0, 0, 1, 0);
      idle(2);
      chk("clr_nowin", wins - w0, 0);
      chk("clr_hold_peak", peak, 40);
      for (int i = 0; i < 4; i++) step(2055, 1, 2, 0, 0);
      idle(2);
      chk("clr_wins", wins - w0, 1);
      chk("clr_peak", peak, 7);
      chk("clr_avg", avg, 7);

      // reset mid-window
      for (int i = 0; i < 3; i++) step(2148, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("rstmid_peak", peak, 0);
      chk("rstmid_mvld", mag_valid, 0);
      w0 = wins;
      for (int i = 0; i < 4; i++) step(2148, 1, 1, 0, 0);
      idle(2);
      chk("rstmid_wins", wins - w0, 1);
      chk("rstmid_peak2", peak, 100);
      chk("rstmid_avg2", avg, 100);

      // randomized traffic, modes, clears and occasional resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, (1 << DW) - 1),
              ($urandom_range(0, 3) != 0),
              $urandom_range(0, 3),
              ($urandom_range(0, 40) == 0),
              ($urandom_range(0, 500) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
